multicycle_controller: RTL and testbench

Sequencing control unit for the multi-cycle RV32I core variant. It steps one instruction at a time through fetch, decode, execute, memory and writeback states, and drives the shared ALU, register file, PC and unified instruction/data memory. It supports a ready-handshaked memory port and traps on unsupported opcodes. It reuses the single-cycle core's ALU encoding and immediate-select encoding, so the datapath blocks are unchanged.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_alu_decoder.sv | 39 +++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : encodings shared by the multi-cycle and single-cycle RV32I cores
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// ============================================================================
// mc_alu_decoder : maps ALU operation class and funct fields to ALU control
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op5 separates R-type sub from I-type addi with imm[10] set
          3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_o     = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : fetch/decode/execute/memory/writeback sequencer
// Revision              : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_control_o,
  output logic       retire_o,
  output logic       trap_o
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       alu_illegal;

  mc_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .op5_i         (op_i[5]),
    .alu_control_o (alu_control_o),
    .illegal_o     (alu_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    retire_o     = 1'b0;
    trap_o       = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    imm_src_o    = IMM_I;
    alu_op       = ALUOP_ADD;

    case (state_q)
      FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = imm_sel(op_i);
        case (op_i)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BEQ;
          OP_JAL:            state_d = JAL;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = imm_sel(op_i);
        state_d     = op_i[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = MEMWB;
      end
      MEMWB: begin
        result_src_o = RES_MEMDATA;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = FETCH;
        end
      end
      EXECR: begin
        alu_src_a_o = SRCA_RS1;
        alu_op      = ALUOP_FUNCT;
        state_d     = alu_illegal ? TRAP : ALUWB;
      end
      EXECI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_d     = alu_illegal ? TRAP : ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      BEQ: begin
        alu_src_a_o = SRCA_RS1;
        alu_op      = ALUOP_SUB;
        pc_write_o  = zero_i;
        retire_o    = 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_d     = ALUWB;
      end
      TRAP:    trap_o  = 1'b1;
      default: state_d = FETCH;
    endcase

    // The state register clears asynchronously, but enables must also be
    // masked in the reset cycle itself so no write escapes mid-abort.
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      retire_o    = 1'b0;
      trap_o      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller : table vectors, corner sequences, random model
// Revision                 : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_controller;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] op_i = '0;
  logic [2:0] funct3_i = '0;
  logic       funct7b5_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
  logic [2:0] alu_control_o;
  logic       retire_o, trap_o;

  always #5 clk_i = ~clk_i;

  multicycle_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .imm_src_o(imm_src_o), .alu_control_o(alu_control_o), .retire_o(retire_o),
    .trap_o(trap_o)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] imm_src;
    logic [2:0] alu;
    logic       retire;
    logic       trap;
  } ctl_t;

  ctl_t act;
  assign act = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o, alu_control_o,
                retire_o, trap_o};

  int checks = 0;
  int failures = 0;

  task automatic check_ctl(input logic [95:0] name, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %0s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic check_val(input logic [95:0] name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %0s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [1:0] a, input logic [1:0] b, input logic [2:0] alu,
                              input logic [1:0] res, input logic [1:0] imm);
    ctl_t c;
    c = '0;
    c.src_a = a; c.src_b = b; c.alu = alu; c.result_src = res; c.imm_src = imm;
    return c;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] fmt_of(input logic [6:0] op);
    if (op == T_STORE) return 2'b01;
    if (op == T_BR)    return 2'b10;
    if (op == T_JAL)   return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reset: enables dark, selects at their fetch values, trap cleared at once.
  task automatic apply_reset();
    ctl_t e;
    rst_i = 1'b1;
    #1;
    e = mk(2'b00, 2'b10, 3'b000, 2'b10, 2'b00);
    check_ctl("reset", e);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------- table-driven instruction vectors ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         cycles;   // 0 = never retires (trap)
    logic [2:0] alu3;
    logic       pcw3;
    logic [1:0] imm2;
    logic       rw;
    logic       trap;
  } vec_t;

  vec_t tbl [14];

  // ---------------- random reference model ----------------
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        rdy;
    logic        zero;
    ctl_t        exp;
    logic [95:0] ph;
  } step_t;

  step_t q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  task automatic push(input logic rdy, input logic z, input ctl_t e, input logic [95:0] ph);
    step_t s;
    s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
    s.rdy = rdy; s.zero = z; s.exp = e; s.ph = ph;
    q.push_back(s);
  endtask

  // A memory handshake: 0..2 stalled cycles with the request held, then ready.
  task automatic mem_access(input ctl_t hold, input ctl_t done, input logic [95:0] ph);
    int w;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) push(1'b0, rbit(), hold, ph);
    push(1'b1, rbit(), done, ph);
  endtask

  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    ctl_t h, d;
    logic z;
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    h = mk(2'b00, 2'b10, 3'b000, 2'b10, 2'b00);
    h.mem_req = 1'b1;
    d = h; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_access(h, d, "fetch");
    push(rbit(), rbit(), mk(2'b01, 2'b01, 3'b000, 2'b00, fmt_of(op)), "decode");
    if (op == T_LOAD || op == T_STORE) begin
      push(rbit(), rbit(), mk(2'b10, 2'b01, 3'b000, 2'b00, fmt_of(op)), "memadr");
      h = '0; h.mem_req = 1'b1; h.adr_src = 1'b1; h.mem_write = (op == T_STORE);
      d = h; d.retire = (op == T_STORE);
      mem_access(h, d, "memaccess");
      if (op == T_LOAD) begin
        d = mk(2'b00, 2'b00, 3'b000, 2'b01, 2'b00);
        d.reg_write = 1'b1; d.retire = 1'b1;
        push(rbit(), rbit(), d, "memwb");
      end
    end else if (op == T_BR) begin
      z = rbit();
      d = mk(2'b10, 2'b00, 3'b001, 2'b00, 2'b00);
      d.pc_write = z; d.retire = 1'b1;
      push(rbit(), z, d, "beq");
    end else begin
      if (op == T_R)        d = mk(2'b10, 2'b00, alu_of(f3, f7, 1'b1), 2'b00, 2'b00);
      else if (op == T_I)   d = mk(2'b10, 2'b01, alu_of(f3, f7, 1'b0), 2'b00, 2'b00);
      else begin
        d = mk(2'b01, 2'b10, 3'b000, 2'b00, 2'b00);
        d.pc_write = 1'b1;
      end
      push(rbit(), rbit(), d, "execute");
      d = mk(2'b00, 2'b00, 3'b000, 2'b00, 2'b00);
      d.reg_write = 1'b1; d.retire = 1'b1;
      push(rbit(), rbit(), d, "aluwb");
    end
  endtask

  logic lw_rdy [1:10];

  initial begin
    int   ret, k;
    logic saw_rw, last_trap, pcw3;
    logic [2:0] alu3;
    logic [1:0] imm2;
    logic [2:0] f3s [4];
    ctl_t e;

    tbl[0]  = '{T_R,     3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{T_R,     3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{T_R,     3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{T_R,     3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{T_R,     3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{T_I,     3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{T_I,     3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{T_LOAD,  3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{T_STORE, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[9]  = '{T_BR,    3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[10] = '{T_BR,    3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{T_JAL,   3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1, 2'b11, 1'b1, 1'b0};
    tbl[12] = '{T_R,     3'b001, 1'b0, 1'b0, 0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[13] = '{7'b0,    3'b000, 1'b0, 1'b0, 0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1};

    @(negedge clk_i);

    for (int n = 0; n < 14; n++) begin
      apply_reset();
      ret = 0; saw_rw = 1'b0; last_trap = 1'b0; alu3 = '0; pcw3 = 1'b0; imm2 = '0;
      k = 0;
      while (k < 10 && ret == 0) begin
        k++;
        op_i = tbl[n].op; funct3_i = tbl[n].f3; funct7b5_i = tbl[n].f7;
        zero_i = tbl[n].zero; mem_ready_i = 1'b1;
        #1;
        if (k == 2) imm2 = imm_src_o;
        if (k == 3) begin alu3 = alu_control_o; pcw3 = pc_write_o; end
        if (reg_write_o) saw_rw = 1'b1;
        if (retire_o) ret = k;
        last_trap = trap_o;
        @(negedge clk_i);
      end
      check_val("vec_cycles", ret, tbl[n].cycles);
      check_val("vec_alu3", int'(alu3), int'(tbl[n].alu3));
      check_val("vec_pcw3", int'(pcw3), int'(tbl[n].pcw3));
      check_val("vec_imm2", int'(imm2), int'(tbl[n].imm2));
      check_val("vec_regwr", int'(saw_rw), int'(tbl[n].rw));
      check_val("vec_trap", int'(last_trap), int'(tbl[n].trap));
      if (tbl[n].trap) begin
        rst_i = 1'b1;
        #1;
        check_val("trap_async_clr", int'(trap_o), 0);
        @(negedge clk_i);
      end
    end

    // lw with two stalled MEMREAD cycles
    lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    ret = 0; k = 0;
    while (k < 10 && ret == 0) begin
      k++;
      op_i = T_LOAD; funct3_i = 3'b010; funct7b5_i = 1'b0; mem_ready_i = lw_rdy[k];
      #1;
      if (k >= 4 && k <= 6)
        check_val("lw_hold", int'({mem_req_o, adr_src_o, mem_write_o}), 6);
      if (retire_o) begin
        ret = k;
        check_val("lw_wb_res", int'(result_src_o), 1);
      end
      @(negedge clk_i);
    end
    check_val("lw_cycles", ret, 7);

    // reset pulse while MEMWRITE sees ready
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      op_i = T_STORE; funct3_i = 3'b010; mem_ready_i = 1'b1;
      @(negedge clk_i);
    end
    #1;
    check_val("sw_memwrite", int'(mem_write_o), 1);
    #1 rst_i = 1'b1;
    #1;
    check_val("sw_rst_en", int'({mem_req_o, mem_write_o, retire_o}), 0);
    @(negedge clk_i);
    mem_ready_i = 1'b0; rst_i = 1'b0;
    #1;
    e = mk(2'b00, 2'b10, 3'b000, 2'b10, 2'b00);
    e.mem_req = 1'b1;
    check_ctl("sw_release", e);
    @(negedge clk_i);

    // randomized instruction stream against the reference model
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111};
    apply_reset();
    q.delete();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: gen_instr(T_LOAD,  3'b010, rbit());
        1: gen_instr(T_STORE, 3'b010, rbit());
        2: gen_instr(T_R,     f3s[$urandom_range(0, 3)], rbit());
        3: gen_instr(T_I,     f3s[$urandom_range(0, 3)], rbit());
        4: gen_instr(T_BR,    3'b000, rbit());
        default: gen_instr(T_JAL, 3'(($urandom_range(0, 7))), rbit());
      endcase
    end
    foreach (q[i]) begin
      op_i = q[i].op; funct3_i = q[i].f3; funct7b5_i = q[i].f7;
      mem_ready_i = q[i].rdy; zero_i = q[i].zero;
      #1;
      check_ctl(q[i].ph, q[i].exp);
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
